// File: rtl/dipsw_poll_ctrl_if.sv
// Bus bundle for dipsw_poll_ctrl: PIO polling port, Avalon-MM CSR slave and interrupt.
// slave = the controller's view; master = the surrounding system (CPU interconnect + PIO).
interface dipsw_poll_ctrl_if;
   logic [1:0]  pio_address;
   logic [31:0] pio_readdata;
   logic [1:0]  s_address;
   logic        s_read;
   logic        s_write;
   logic [31:0] s_writedata;
   logic [31:0] s_readdata;
   logic        irq;

   modport slave (
      output pio_address, s_readdata, irq,
      input  pio_readdata, s_address, s_read, s_write, s_writedata
   );

   modport master (
      input  pio_address, s_readdata, irq,
      output pio_readdata, s_address, s_read, s_write, s_writedata
   );
endinterface

// File: rtl/dipsw_poll_ctrl.sv
// DIP-switch PIO poller: periodic PIO read, debounce, sticky change flags, IRQ, 4-word CSR.
// Define DIPSW_POLL_DEBOUNCE_EN to require DEB_CNT identical samples; otherwise every sample is accepted.
module dipsw_poll_ctrl #(
   parameter int WIDTH    = 4,
   parameter int PERIOD_W = 16,
   parameter int DEB_CNT  = 4
) (
   input logic              clk,
   input logic              reset,
   dipsw_poll_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, REQ, EVAL} fsm_t;

   fsm_t                fsm_q;
   logic [1:0]          pio_addr_q;
   logic [1:0]          ctrl_q, ctrl_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic [PERIOD_W-1:0] presc_q, presc_d;
   logic [WIDTH-1:0]    state_q, state_d;
   logic [WIDTH-1:0]    edge_q, edge_d;
   logic [WIDTH-1:0]    sample, edge_set, w1c;
   logic [31:0]         rdata_q, rdata_d;
   logic                poll_tick, eval_ok;
   logic                unused_bits;

`ifdef DIPSW_POLL_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEB_CNT + 1);
   logic [WIDTH-1:0] last_q, last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

   assign unused_bits = ^{bus.pio_readdata, bus.s_writedata};
   assign sample      = bus.pio_readdata[WIDTH-1:0];
   // Abort uses the post-write enable so a CTRL write clearing enable drops the in-flight sample.
   assign eval_ok     = (fsm_q == EVAL) && ctrl_d[0];

   always_comb begin
      ctrl_d    = ctrl_q;
      period_d  = period_q;
      presc_d   = presc_q;
      poll_tick = 1'b0;
      w1c       = '0;
      if (bus.s_write) begin
         case (bus.s_address)
            2'd0:    ctrl_d   = bus.s_writedata[1:0];
            2'd1:    period_d = bus.s_writedata[PERIOD_W-1:0];
            2'd3:    w1c      = bus.s_writedata[WIDTH-1:0];
            default: ;
         endcase
      end

      if (ctrl_q[0]) begin
         if (presc_q == '0) begin
            presc_d   = period_q;
            poll_tick = 1'b1;
         end else begin
            presc_d = presc_q - 1'b1;
         end
      end

      state_d  = state_q;
      edge_set = '0;
`ifdef DIPSW_POLL_DEBOUNCE_EN
      last_d = last_q;
      cnt_d  = cnt_q;
      if (eval_ok) begin
         if (sample == last_q) begin
            if (cnt_q != CNT_W'(DEB_CNT))
               cnt_d = cnt_q + 1'b1;
         end else begin
            last_d = sample;
            cnt_d  = CNT_W'(1);
         end
         if ((cnt_d == CNT_W'(DEB_CNT)) && (last_d != state_q)) begin
            edge_set = state_q ^ last_d;
            state_d  = last_d;
         end
      end
`else
      if (eval_ok && (sample != state_q)) begin
         edge_set = state_q ^ sample;
         state_d  = sample;
      end
`endif
      // Hardware set wins over a same-cycle W1C on the same bit.
      edge_d = (edge_q & ~w1c) | edge_set;

      rdata_d = rdata_q;
      if (bus.s_read) begin
         case (bus.s_address)
            2'd0:    rdata_d = 32'(ctrl_q);
            2'd1:    rdata_d = 32'(period_q);
            2'd2:    rdata_d = 32'(state_q);
            default: rdata_d = 32'(edge_q);
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fsm_q      <= IDLE;
         pio_addr_q <= 2'd3;
         ctrl_q     <= '0;
         period_q   <= '0;
         presc_q    <= '0;
         state_q    <= '0;
         edge_q     <= '0;
         rdata_q    <= '0;
`ifdef DIPSW_POLL_DEBOUNCE_EN
         last_q     <= '0;
         cnt_q      <= '0;
`endif
      end else begin
         ctrl_q   <= ctrl_d;
         period_q <= period_d;
         presc_q  <= presc_d;
         state_q  <= state_d;
         edge_q   <= edge_d;
         rdata_q  <= rdata_d;
`ifdef DIPSW_POLL_DEBOUNCE_EN
         last_q   <= last_d;
         cnt_q    <= cnt_d;
`endif
         if (!ctrl_d[0]) begin
            fsm_q      <= IDLE;
            pio_addr_q <= 2'd3;
         end else begin
            case (fsm_q)
               IDLE: begin
                  if (poll_tick) begin
                     fsm_q      <= REQ;
                     pio_addr_q <= 2'd0;
                  end
               end
               REQ: begin
                  fsm_q      <= EVAL;
                  pio_addr_q <= 2'd3;
               end
               default: begin
                  fsm_q      <= IDLE;
                  pio_addr_q <= 2'd3;
               end
            endcase
         end
      end
   end

   assign bus.pio_address = pio_addr_q;
   assign bus.s_readdata  = rdata_q;
   assign bus.irq         = ctrl_q[1] & (|edge_q);

endmodule
